serial_add_seq: RTL

- Bit-serial adder sequencer that drives the single-bit full-adder stage (a, b, cin -> sum, cout), LSB first, one bit per clock.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and shifts them through a registered carry loop.
- Presents the WIDTH-bit sum and final carry-out on a valid/ready output handshake.
- Sits between the operand source (ui_in pins / upstream register) and the result consumer (uo_out pins).

---
 rtl/serial_add_seq_pkg.sv | 19 +
 rtl/serial_add_seq_fa_cell.sv | 14 +
 rtl/serial_add_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_add_seq_pkg.sv
// Shared types for the bit-serial adder sequencer.
// State encoding and counter sizing helper.
package serial_add_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   // Bit-counter width for a given operand width (at least one bit)
   function automatic int cnt_bits(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// Single-bit full adder used in the serial carry loop.
// Purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer, LSB first, one bit per clock.
// Optional subtract mode: define SERIAL_ADD_SUB_EN.
module serial_add_seq
   import serial_add_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic [WIDTH-1:0] s_next;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_s),
      .cout (fa_co)
   );

   assign s_next = {fa_s, s_sr[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
   // Subtract loads the inverted B operand with a forced carry of one
   always_comb begin
      b_load = in_b;
      c_load = in_cin;
      if (in_sub) begin
         b_load = ~in_b;
         c_load = 1'b1;
      end
   end
`else
   logic unused_sub;
   assign unused_sub = in_sub;
   assign b_load     = in_b;
   assign c_load     = in_cin;
`endif

   // Sequencer FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         s_sr      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sr     <= in_a;
                  b_sr     <= b_load;
                  carry    <= c_load;
                  s_sr     <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               s_sr  <= s_next;
               carry <= fa_co;
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // Last bit: operand MSBs sit at bit 0 of the shifters
                  out_sum   <= s_next;
                  out_cout  <= fa_co;
                  out_ovf   <= (a_sr[0] == b_sr[0]) && (fa_s != a_sr[0]);
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
